// File: rtl/obstacle_pkg.sv
// obstacle_pkg: shared types, widths and obstacle type table for the obstacle spawner
package obstacle_pkg;

    localparam int X_W = 10;
    localparam int H_W = 7;
    localparam int W_W = 8;

    // Fibonacci taps 16,14,13,11 expressed as state bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {IDLE, GAP, SCROLL, HALT} state_t;

    typedef struct packed {
        logic [W_W-1:0] w;
        logic [H_W-1:0] h;
    } obs_type_t;

    function automatic obs_type_t obs_lookup(input logic [1:0] sel);
        obs_type_t t;
        case (sel)
            2'd0:    t = '{w: 8'd17, h: 7'd35};
            2'd1:    t = '{w: 8'd34, h: 7'd35};
            2'd2:    t = '{w: 8'd25, h: 7'd50};
            default: t = '{w: 8'd51, h: 7'd50};
        endcase
        return t;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR shared by the spawners
module lfsr16
    import obstacle_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state
);

    // shift left, feeding the parity of the tapped bits into bit 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SEED;
        else        state <= {state[14:0], ^(state & LFSR_TAPS)};
    end

endmodule

// File: rtl/obstacle_scroller.sv
// obstacle_scroller: spawns, scrolls and retires one obstacle at a time, freezing on collision
module obstacle_scroller
    import obstacle_pkg::*;
#(
    parameter int          SCREEN_W  = 640,
    parameter int          SPEED     = 4,
    parameter int          MIN_GAP   = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           frame_tick,
    input  logic           start,
    input  logic           collided,
    output logic [X_W-1:0] obs_x,
    output logic [H_W-1:0] obs_h,
    output logic [W_W-1:0] obs_w,
    output logic           obs_valid,
    output logic           obs_passed,
    output logic           halted
);

    localparam logic [X_W-1:0] X_OFF   = X_W'(SCREEN_W);
    localparam logic [X_W-1:0] X_SPAWN = X_W'(SCREEN_W - 1);
    localparam logic [X_W-1:0] X_STEP  = X_W'(SPEED);

    state_t      state;
    logic [7:0]  gap_cnt;
    logic [7:0]  gap_load;
    logic [15:0] lfsr;
    obs_type_t   typ;

    // entropy source keeps running in every state so start timing varies the sequence
    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .state (lfsr)
    );

    assign gap_load = 8'(MIN_GAP) + {3'b000, lfsr[4:0]};
    assign typ      = obs_lookup(lfsr[1:0]);

    // game flow: wait for start, count the gap, scroll the obstacle, freeze on a hit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            obs_x      <= X_OFF;
            obs_h      <= '0;
            obs_w      <= '0;
            obs_valid  <= 1'b0;
            obs_passed <= 1'b0;
            halted     <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            obs_passed <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        gap_cnt <= gap_load;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (frame_tick) begin
                        if (gap_cnt != '0) begin
                            gap_cnt <= gap_cnt - 8'd1;
                        end else begin
                            obs_x     <= X_SPAWN;
                            obs_w     <= typ.w;
                            obs_h     <= typ.h;
                            obs_valid <= 1'b1;
                            state     <= SCROLL;
                        end
                    end
                end
                SCROLL: begin
                    // a hit takes priority so the frozen x is the one that collided
                    if (collided) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else if (frame_tick) begin
                        if (obs_x >= X_STEP) begin
                            obs_x <= obs_x - X_STEP;
                        end else begin
                            obs_valid  <= 1'b0;
                            obs_x      <= X_OFF;
                            obs_passed <= 1'b1;
                            gap_cnt    <= gap_load;
                            state      <= GAP;
                        end
                    end
                end
                HALT: begin
                    if (start) begin
                        obs_valid <= 1'b0;
                        obs_x     <= X_OFF;
                        halted    <= 1'b0;
                        gap_cnt   <= gap_load;
                        state     <= GAP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_scroller.sv
// tb_obstacle_scroller: randomized scenario bench with a behavioural model of spawn, scroll and freeze
module tb_obstacle_scroller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       collided = 1'b0;
    logic [9:0] obs_x;
    logic [6:0] obs_h;
    logic [7:0] obs_w;
    logic       obs_valid;
    logic       obs_passed;
    logic       halted;

    int vec = 0;
    int err = 0;
    int cur_x, cur_w, cur_h, next_gap;
    int tw[4] = '{17, 34, 25, 51};
    int th[4] = '{35, 35, 50, 50};
    logic [15:0] ref_lfsr;

    obstacle_scroller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .start      (start),
        .collided   (collided),
        .obs_x      (obs_x),
        .obs_h      (obs_h),
        .obs_w      (obs_w),
        .obs_valid  (obs_valid),
        .obs_passed (obs_passed),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // reference copy of the random sequence: seed on reset, one step per clock
    always @(posedge clk or negedge rst_n) ref_lfsr <= !rst_n ? 16'hACE1 : lfsr_next(ref_lfsr);

    // drive one clock of inputs; l is the random state the design sees at that edge
    task automatic cyc(input logic ft, input logic st, input logic col, output logic [15:0] l);
        frame_tick = ft;
        start = st;
        collided = col;
        l = ref_lfsr;
        @(negedge clk);
        frame_tick = 1'b0;
        start = 1'b0;
        collided = 1'b0;
    endtask

    // zero to two quiet frames carrying inputs that must be ignored
    task automatic idle_noise(input logic allow_col);
        repeat ($urandom_range(0, 2)) begin
            start = 1'($urandom_range(0, 1));
            collided = allow_col & 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        start = 1'b0;
        collided = 1'b0;
    endtask

    task automatic do_gap(input int g);
        logic [15:0] l;
        for (int i = 0; i <= g; i++) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), l);
            vec++;
            if (i < g) begin
                if ({obs_valid, halted, obs_x} !== {2'b00, 10'd640}) begin
                    err++;
                    $display("FAIL gap_wait tick %0d: valid/halted/x=%b/%b/%0d want 0/0/640", i, obs_valid, halted, obs_x);
                end
                idle_noise(1'b1);
            end else begin
                cur_x = 639;
                cur_w = tw[l[1:0]];
                cur_h = th[l[1:0]];
                if ({obs_valid, halted, obs_x, obs_w, obs_h} !== {2'b10, 10'd639, 8'(cur_w), 7'(cur_h)}) begin
                    err++;
                    $display("FAIL spawn: valid/halted/x/w/h=%b/%b/%0d/%0d/%0d want 1/0/639/%0d/%0d",
                             obs_valid, halted, obs_x, obs_w, obs_h, cur_w, cur_h);
                end
            end
        end
    endtask

    task automatic scroll(input int k);
        logic [15:0] l;
        for (int i = 0; i < k; i++) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, l);
            cur_x -= 4;
            vec++;
            if ({obs_valid, obs_passed, halted, obs_x} !== {3'b100, 10'(cur_x)}) begin
                err++;
                $display("FAIL scroll: valid/passed/halted/x=%b/%b/%b/%0d want 1/0/0/%0d",
                         obs_valid, obs_passed, halted, obs_x, cur_x);
            end
            idle_noise(1'b0);
        end
    endtask

    task automatic collide(input logic ft, input int freeze_ticks);
        logic [15:0] l;
        cyc(ft, 1'b0, 1'b1, l);
        vec++;
        if ({obs_valid, halted, obs_x, obs_w, obs_h} !== {2'b11, 10'(cur_x), 8'(cur_w), 7'(cur_h)}) begin
            err++;
            $display("FAIL collide: valid/halted/x/w/h=%b/%b/%0d/%0d/%0d want 1/1/%0d/%0d/%0d",
                     obs_valid, halted, obs_x, obs_w, obs_h, cur_x, cur_w, cur_h);
        end
        for (int i = 0; i < freeze_ticks; i++) begin
            cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), l);
            vec++;
            if ({obs_valid, halted, obs_x, obs_w, obs_h} !== {2'b11, 10'(cur_x), 8'(cur_w), 7'(cur_h)}) begin
                err++;
                $display("FAIL halt_freeze tick %0d: valid/halted/x=%b/%b/%0d want 1/1/%0d", i, obs_valid, halted, obs_x, cur_x);
            end
        end
    endtask

    task automatic restart();
        logic [15:0] l;
        cyc(1'b0, 1'b1, 1'b0, l);
        next_gap = 16 + int'(l[4:0]);
        vec++;
        if ({obs_valid, halted, obs_x} !== {2'b00, 10'd640}) begin
            err++;
            $display("FAIL restart: valid/halted/x=%b/%b/%0d want 0/0/640", obs_valid, halted, obs_x);
        end
    endtask

    task automatic test_reset();
        logic [15:0] l;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        vec++;
        if ({obs_x, obs_h, obs_w, obs_valid, obs_passed, halted} !== {10'd640, 7'd0, 8'd0, 3'b000}) begin
            err++;
            $display("FAIL reset_outputs: x/h/w/v/p/hl=%0d/%0d/%0d/%b/%b/%b want 640/0/0/0/0/0",
                     obs_x, obs_h, obs_w, obs_valid, obs_passed, halted);
        end
        vec++;
        if (dut.u_lfsr.state !== 16'hACE1) begin
            err++;
            $display("FAIL reset_lfsr: got %h want ace1", dut.u_lfsr.state);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b1, l);
            vec++;
            if ({obs_valid, halted, obs_x} !== {2'b00, 10'd640}) begin
                err++;
                $display("FAIL idle_ignore: valid/halted/x=%b/%b/%0d want 0/0/640", obs_valid, halted, obs_x);
            end
        end
    endtask

    task automatic test_spawn(input int wait_cycles);
        repeat (wait_cycles) @(negedge clk);
        restart();
        do_gap(next_gap);
    endtask

    task automatic test_scroll();
        logic [15:0] l;
        scroll(1);
        scroll(158);
        cyc(1'b1, 1'b0, 1'b0, l);
        next_gap = 16 + int'(l[4:0]);
        vec++;
        if ({obs_valid, obs_passed, halted, obs_x} !== {3'b010, 10'd640}) begin
            err++;
            $display("FAIL retire: valid/passed/halted/x=%b/%b/%b/%0d want 0/1/0/640", obs_valid, obs_passed, halted, obs_x);
        end
        cyc(1'b0, 1'b0, 1'b0, l);
        vec++;
        if (obs_passed !== 1'b0) begin
            err++;
            $display("FAIL passed_pulse: got %b want 0", obs_passed);
        end
    endtask

    task automatic test_collision();
        do_gap(next_gap);
        scroll(84);
        collide(1'b0, 20);
        restart();
        do_gap(next_gap);
    endtask

    task automatic test_collide_with_tick();
        scroll(134);
        collide(1'b1, 3);
        restart();
    endtask

    task automatic test_random_collide();
        for (int r = 0; r < 3; r++) begin
            do_gap(next_gap);
            scroll($urandom_range(0, 150));
            collide(1'($urandom_range(0, 1)), $urandom_range(1, 5));
            restart();
        end
    endtask

    task automatic test_async_reset();
        do_gap(next_gap);
        scroll(109);
        vec++;
        if (dut.u_lfsr.state !== ref_lfsr) begin
            err++;
            $display("FAIL lfsr_track: got %h want %h", dut.u_lfsr.state, ref_lfsr);
        end
        #2 rst_n = 1'b0;
        #1;
        vec++;
        if ({obs_x, obs_h, obs_w, obs_valid, obs_passed, halted} !== {10'd640, 7'd0, 8'd0, 3'b000}) begin
            err++;
            $display("FAIL async_reset: x/h/w/v/p/hl=%0d/%0d/%0d/%b/%b/%b want 640/0/0/0/0/0",
                     obs_x, obs_h, obs_w, obs_valid, obs_passed, halted);
        end
        vec++;
        if (dut.u_lfsr.state !== 16'hACE1) begin
            err++;
            $display("FAIL async_reset_lfsr: got %h want ace1", dut.u_lfsr.state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_spawn(4);
    endtask

    initial begin
        test_reset();
        test_spawn(6);
        test_scroll();
        test_collision();
        test_collide_with_tick();
        test_random_collide();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, want finish before 2ms");
        $fatal(1);
    end

endmodule
